// File: rtl/scanconverter_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : scanconverter_mode_ctrl
// Brief   : Measures incoming H/V sync timing, qualifies a stable video mode
//           and drives the scan-converter line-multiplier configuration.
// Revision: 1.0 - initial release
// ============================================================================
module scanconverter_mode_ctrl #(
  parameter int STABLE_FRAMES = 3,
  parameter int H_TOL         = 2,
  parameter int LOCK_FRAMES   = 8,
  parameter int H_MIN         = 400,
  parameter int H_MAX         = 600,
  parameter int V_MIN         = 240,
  parameter int V_MAX         = 280
) (
  input  logic        PCLK_in,
  input  logic        reset,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  input  logic        pll_lock,
  input  logic [1:0]  req_mode,
  output logic [1:0]  H_LINEMULT,
  output logic [10:0] H_ACTIVE,
  output logic [7:0]  H_BACKPORCH,
  output logic [7:0]  H_SYNCLEN,
  output logic [10:0] V_ACTIVE,
  output logic [5:0]  V_BACKPORCH,
  output logic [3:0]  V_SYNCLEN,
  output logic        cfg_update,
  output logic        mode_valid,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic [1:0]  state
);

  localparam logic [1:0] SEARCH   = 2'd0;
  localparam logic [1:0] VERIFY   = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;
  localparam logic [1:0] FALLBACK = 2'd3;

  localparam logic [11:0] H_TOL_V  = 12'(H_TOL);
  localparam logic [11:0] H_MIN_V  = 12'(H_MIN);
  localparam logic [11:0] H_MAX_V  = 12'(H_MAX);
  localparam logic [10:0] V_MIN_V  = 11'(V_MIN);
  localparam logic [10:0] V_MAX_V  = 11'(V_MAX);
  localparam logic [3:0]  STABLE_N = 4'(STABLE_FRAMES);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  logic [1:0]  cur_state, nxt_state;
  logic        hs_prev, vs_prev;
  logic [11:0] h_cnt, prev_line, last_line, ref_h;
  logic [10:0] v_cnt, ref_v;
  logic        h_seen, prev_valid, bad, loss, armed;
  logic [3:0]  stable_cnt, nxt_stable, lock_cnt, nxt_lock;
  logic        ref_load;

  logic        h_edge, v_edge, h_sat, v_sat, line_ok, tol_fail, frame_bad;
  logic        frame_end, loss_now, in_win, valid, match;
  logic [11:0] line_len, line_diff, h_new, h_dev;
  logic [10:0] v_new;
  logic [1:0]  eff_mode;

  logic [1:0]  n_linemult;
  logic [10:0] n_h_active, n_v_active;
  logic [7:0]  n_h_bp, n_h_sl;
  logic [5:0]  n_v_bp;
  logic [3:0]  n_v_sl;

  assign h_edge    = hs_prev & ~HSYNC_in;
  assign v_edge    = vs_prev & ~VSYNC_in;
  assign h_sat     = (h_cnt == 12'hFFF);
  assign v_sat     = (v_cnt == 11'h7FF);
  assign line_len  = h_sat ? 12'hFFF : h_cnt + 12'd1;
  assign line_ok   = h_edge & h_seen;
  assign line_diff = (line_len >= prev_line) ? line_len - prev_line : prev_line - line_len;
  assign tol_fail  = line_ok & prev_valid & (line_diff > H_TOL_V);
  assign frame_bad = bad | tol_fail | h_sat | v_sat;
  // A line closing on the frame-end cycle belongs to the closing frame.
  assign h_new     = line_ok ? line_len : last_line;
  assign v_new     = (h_edge && !v_sat) ? v_cnt + 11'd1 : v_cnt;
  assign frame_end = v_edge & armed;
  assign loss_now  = loss | ~pll_lock;
  assign in_win    = (h_new >= H_MIN_V) && (h_new <= H_MAX_V) &&
                     (v_new >= V_MIN_V) && (v_new <= V_MAX_V);
  assign valid     = ~frame_bad & in_win;
  assign h_dev     = (h_new >= ref_h) ? h_new - ref_h : ref_h - h_new;
  assign match     = valid && (h_dev <= H_TOL_V) && (v_new == ref_v);
  assign eff_mode  = (req_mode == 2'd3) ? 2'd0 : req_mode;

  always_ff @(posedge PCLK_in) begin
    if (reset) cur_state <= SEARCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = cur_state;
    nxt_stable = stable_cnt;
    nxt_lock   = lock_cnt;
    ref_load   = 1'b0;
    if (frame_end) begin
      case (cur_state)
        SEARCH: begin
          if (valid) begin
            ref_load   = 1'b1;
            nxt_stable = 4'd1;
            nxt_state  = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            nxt_stable = stable_cnt + 4'd1;
            if (nxt_stable == STABLE_N) nxt_state = LOCKED;
          end else begin
            nxt_stable = 4'd0;
            nxt_state  = SEARCH;
          end
        end
        LOCKED: begin
          if (!match) begin
            nxt_stable = 4'd0;
            nxt_state  = SEARCH;
          end else if (loss_now && eff_mode != 2'd0) begin
            nxt_lock  = 4'd0;
            nxt_state = FALLBACK;
          end
        end
        default: begin
          if (!match) begin
            nxt_stable = 4'd0;
            nxt_state  = SEARCH;
          end else if (!loss_now) begin
            nxt_lock = lock_cnt + 4'd1;
            if (nxt_lock == LOCK_N) nxt_state = LOCKED;
          end else begin
            nxt_lock = 4'd0;
          end
        end
      endcase
    end
  end

  // Profile follows the state being entered so config and state change together.
  always_comb begin
    n_linemult = 2'd0;  n_h_active = 11'd960; n_h_bp = 8'd20;  n_h_sl = 8'd20;
    n_v_active = 11'd224; n_v_bp = 6'd28; n_v_sl = 4'd3;
    if (nxt_state == LOCKED) begin
      if (eff_mode == 2'd1) begin
        n_linemult = 2'd1;  n_h_active = 11'd768;  n_h_bp = 8'd132; n_h_sl = 8'd62;
        n_v_active = 11'd240; n_v_bp = 6'd16; n_v_sl = 4'd3;
      end else if (eff_mode == 2'd2) begin
        n_linemult = 2'd2;  n_h_active = 11'd1920; n_h_bp = 8'd148; n_h_sl = 8'd44;
        n_v_active = 11'd240; n_v_bp = 6'd16; n_v_sl = 4'd3;
      end
    end
  end

  assign mode_valid = (cur_state == LOCKED);
  assign state      = cur_state;

  always_ff @(posedge PCLK_in) begin
    if (reset) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      prev_line  <= '0;
      last_line  <= '0;
      h_seen     <= 1'b0;
      prev_valid <= 1'b0;
      bad        <= 1'b0;
      loss       <= 1'b0;
      armed      <= 1'b0;
      h_total    <= '0;
      v_total    <= '0;
      ref_h      <= '0;
      ref_v      <= '0;
      stable_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      hs_prev    <= HSYNC_in;
      vs_prev    <= VSYNC_in;
      stable_cnt <= nxt_stable;
      lock_cnt   <= nxt_lock;
      if (h_edge) begin
        h_cnt  <= '0;
        h_seen <= 1'b1;
        if (h_seen) begin
          prev_line  <= line_len;
          last_line  <= line_len;
          prev_valid <= 1'b1;
        end
      end else if (!h_sat) begin
        h_cnt <= h_cnt + 12'd1;
      end
      if (v_edge) begin
        v_cnt <= '0;
        armed <= 1'b1;
        bad   <= 1'b0;
        loss  <= 1'b0;
        if (armed) begin
          h_total <= h_new;
          v_total <= v_new;
        end
      end else begin
        v_cnt <= v_new;
        bad   <= frame_bad;
        loss  <= loss_now;
      end
      if (ref_load) begin
        ref_h <= h_new;
        ref_v <= v_new;
      end
    end
  end

  always_ff @(posedge PCLK_in) begin
    if (reset) begin
      H_LINEMULT  <= 2'd0;
      H_ACTIVE    <= 11'd960;
      H_BACKPORCH <= 8'd20;
      H_SYNCLEN   <= 8'd20;
      V_ACTIVE    <= 11'd224;
      V_BACKPORCH <= 6'd28;
      V_SYNCLEN   <= 4'd3;
      cfg_update  <= 1'b0;
    end else if (frame_end) begin
      H_LINEMULT  <= n_linemult;
      H_ACTIVE    <= n_h_active;
      H_BACKPORCH <= n_h_bp;
      H_SYNCLEN   <= n_h_sl;
      V_ACTIVE    <= n_v_active;
      V_BACKPORCH <= n_v_bp;
      V_SYNCLEN   <= n_v_sl;
      cfg_update  <= {n_linemult, n_h_active, n_h_bp, n_h_sl, n_v_active, n_v_bp, n_v_sl} !=
                     {H_LINEMULT, H_ACTIVE, H_BACKPORCH, H_SYNCLEN, V_ACTIVE, V_BACKPORCH, V_SYNCLEN};
    end else begin
      cfg_update  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scanconverter_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_scanconverter_mode_ctrl
// Brief   : Directed self-checking bench; frames are scaled to 32x10 so the
//           window parameters are overridden to keep the run short.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scanconverter_mode_ctrl;

  localparam int HL = 32;
  localparam int VL = 10;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync, pll_lock;
  logic [1:0]  req_mode;
  logic [1:0]  h_linemult;
  logic [10:0] h_active, v_active;
  logic [7:0]  h_bp, h_sl;
  logic [5:0]  v_bp;
  logic [3:0]  v_sl;
  logic        cfg_update, mode_valid;
  logic [11:0] h_total;
  logic [10:0] v_total;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scanconverter_mode_ctrl #(
    .STABLE_FRAMES(3), .H_TOL(2), .LOCK_FRAMES(8),
    .H_MIN(20), .H_MAX(40), .V_MIN(8), .V_MAX(12)
  ) dut (
    .PCLK_in(clk), .reset(reset), .HSYNC_in(hsync), .VSYNC_in(vsync),
    .pll_lock(pll_lock), .req_mode(req_mode),
    .H_LINEMULT(h_linemult), .H_ACTIVE(h_active), .H_BACKPORCH(h_bp),
    .H_SYNCLEN(h_sl), .V_ACTIVE(v_active), .V_BACKPORCH(v_bp), .V_SYNCLEN(v_sl),
    .cfg_update(cfg_update), .mode_valid(mode_valid),
    .h_total(h_total), .v_total(v_total), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One line: sync edge on the last cycle, optional VSYNC edge with it,
  // optional single-cycle pll_lock drop early in the line.
  task automatic line(input int len, input bit vs, input bit drop);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      hsync    = (c != len - 1);
      vsync    = !(vs && c == len - 1);
      pll_lock = !(drop && c == 5);
    end
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(HL, 1'b0, 1'b0);
  endtask

  task automatic fe_line(input int len);
    line(len, 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    lines(VL - 1);
    fe_line(HL);
  endtask

  task automatic chk_double(input string tag);
    chk({tag, "_lm"},  h_linemult, 1);
    chk({tag, "_ha"},  h_active, 768);
    chk({tag, "_hbp"}, h_bp, 132);
    chk({tag, "_hsl"}, h_sl, 62);
    chk({tag, "_va"},  v_active, 240);
    chk({tag, "_vbp"}, v_bp, 16);
    chk({tag, "_vsl"}, v_sl, 3);
  endtask

  task automatic chk_pass(input string tag);
    chk({tag, "_lm"},  h_linemult, 0);
    chk({tag, "_ha"},  h_active, 960);
    chk({tag, "_hbp"}, h_bp, 20);
    chk({tag, "_hsl"}, h_sl, 20);
    chk({tag, "_va"},  v_active, 224);
    chk({tag, "_vbp"}, v_bp, 28);
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; pll_lock = 1'b1; req_mode = 2'd1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_mv", mode_valid, 0);
    chk("rst_cfgu", cfg_update, 0);
    chk("rst_ht", h_total, 0);
    chk("rst_vt", v_total, 0);
    chk_pass("rst");
    chk("rst_vsl", v_sl, 3);
    reset = 1'b0;

    // First frame end is ignored, then 3 matching frames lock.
    repeat (3) frame();
    chk("fe3_state", state, 1);
    chk("fe3_cfgu", cfg_update, 0);
    frame();
    chk("fe4_state", state, 2);
    chk("fe4_mv", mode_valid, 1);
    chk("fe4_cfgu", cfg_update, 1);
    chk_double("fe4");
    chk("fe4_ht", h_total, HL);
    chk("fe4_vt", v_total, VL);

    // One frame with an extra line drops lock.
    lines(VL);
    fe_line(HL);
    chk("vjump_vt", v_total, VL + 1);
    chk("vjump_state", state, 0);
    chk("vjump_cfgu", cfg_update, 1);
    chk("vjump_mv", mode_valid, 0);
    chk_pass("vjump");
    repeat (2) frame();
    chk("relock2_state", state, 1);
    frame();
    chk("relock3_state", state, 2);
    chk("relock3_cfgu", cfg_update, 1);
    chk_double("relock3");

    // Single-cycle PLL drop mid-frame.
    lines(4);
    line(HL, 1'b0, 1'b1);
    lines(4);
    fe_line(HL);
    chk("pll_state", state, 3);
    chk("pll_cfgu", cfg_update, 1);
    chk("pll_mv", mode_valid, 0);
    chk_pass("pll");
    repeat (7) frame();
    chk("fb7_state", state, 3);
    frame();
    chk("fb8_state", state, 2);
    chk("fb8_cfgu", cfg_update, 1);
    chk_double("fb8");

    // req_mode change mid-frame applies only at the next frame end.
    lines(5);
    req_mode = 2'd2;
    lines(4);
    chk("mid_lm", h_linemult, 1);
    chk("mid_state", state, 2);
    fe_line(HL);
    chk("fivex_lm", h_linemult, 2);
    chk("fivex_ha", h_active, 1920);
    chk("fivex_hbp", h_bp, 148);
    chk("fivex_hsl", h_sl, 44);
    chk("fivex_cfgu", cfg_update, 1);
    frame();
    chk("fivex2_cfgu", cfg_update, 0);
    chk("fivex2_lm", h_linemult, 2);

    lines(5);
    req_mode = 2'd3;
    lines(4);
    fe_line(HL);
    chk("rsvd_state", state, 2);
    chk("rsvd_mv", mode_valid, 1);
    chk("rsvd_cfgu", cfg_update, 1);
    chk_pass("rsvd");

    // Alternating 32/35 lines exceed the line-to-line tolerance.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < VL; i++) line((i % 2) ? HL + 3 : HL, i == VL - 1, 1'b0);
      @(posedge clk);
      #1;
      chk("alt_state", state, 0);
      chk("alt_ht", h_total, HL + 3);
      chk("alt_cfgu", cfg_update, 0);
    end

    // 5000-cycle line closing on the VSYNC edge.
    lines(VL - 1);
    fe_line(5000);
    chk("long_ht", h_total, 4095);
    chk("long_vt", v_total, VL);
    chk("long_state", state, 0);

    // Reset mid-frame re-arms the first-frame-end ignore.
    lines(4);
    @(negedge clk);
    hsync = 1'b1; vsync = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_mode = 2'd1;
    chk("mrst_state", state, 0);
    chk("mrst_ht", h_total, 0);
    chk("mrst_vt", v_total, 0);
    chk("mrst_cfgu", cfg_update, 0);
    repeat (3) frame();
    chk("mrst3_state", state, 1);
    frame();
    chk("mrst4_state", state, 2);
    chk("mrst4_cfgu", cfg_update, 1);
    chk("mrst4_lm", h_linemult, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scanconverter_mode_ctrl.md
SCANCONVERTER_MODE_CTRL -- requirements
Module: scanconverter_mode_ctrl

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, 3: number of consecutive matching frames needed to lock.
REQ-002 SHALL have parameter H_TOL, 2: allowed |h_total| deviation in PCLK cycles, line-to-line and frame-to-frame.
REQ-003 SHALL have parameter LOCK_FRAMES, 8: number of clean PLL-locked frames required to leave FALLBACK.
REQ-004 SHALL have parameters H_MIN 400, H_MAX 600, V_MIN 240, V_MAX 280: the accepted measurement window (inclusive).
REQ-005 SHALL have ports PCLK_in in 1 (sole clock, rising edge) and reset in 1 (synchronous, active-high); one clock, synchronous active-high reset.
REQ-006 SHALL have ports HSYNC_in in 1 and VSYNC_in in 1 (active-low syncs, PCLK_in domain); pll_lock in 1; req_mode in 2 (0 = disable, 1 = double, 2 = 5x, 3 = reserved).
REQ-007 SHALL have outputs H_LINEMULT 2, H_ACTIVE 11, H_BACKPORCH 8, H_SYNCLEN 8, V_ACTIVE 11, V_BACKPORCH 6, V_SYNCLEN 4 (registered config).
REQ-008 SHALL have outputs cfg_update 1 (one-cycle pulse), mode_valid 1, h_total 12, v_total 11, and state 2 (SEARCH=0, VERIFY=1, LOCKED=2, FALLBACK=3).

Function
REQ-009 SHALL detect edges from 1-cycle-delayed syncs: a leading edge is prev=1 and current=0; an event is acted on in the cycle it is detected.
REQ-010 SHALL count PCLK cycles between HSYNC leading edges in a 12-bit counter that saturates at 4095; a line's length is the count + 1.
REQ-011 SHALL count HSYNC leading edges between VSYNC leading edges in an 11-bit counter that saturates at 2047; a coincident HSYNC edge counts in the closing frame.
REQ-012 SHALL set a per-frame bad flag when any line length differs from the previous line by more than H_TOL, or when either counter saturates.
REQ-013 SHALL update h_total (last complete line) and v_total on each VSYNC leading edge ("frame end"); all state decisions occur only at frame end.
REQ-014 SHALL ignore the first frame end after reset except to start measurement; it makes no evaluation and no cfg_update.
REQ-015 SHALL define a frame as "valid" when it is not bad and h_total and v_total lie in the window; as "match" when valid, |h_total-ref_h| <= H_TOL and v_total == ref_v.
REQ-016 SHALL handle SEARCH: a valid frame latches ref_h/ref_v, sets stable_cnt=1 and moves to VERIFY; otherwise the FSM stays in SEARCH.
REQ-017 SHALL handle VERIFY: a match increments stable_cnt, and at stable_cnt == STABLE_FRAMES the FSM enters LOCKED; a non-match returns it to SEARCH with stable_cnt=0.
REQ-018 SHALL handle LOCKED: a non-match goes to SEARCH; a latched PLL loss with effective mode != 0 goes to FALLBACK; otherwise the FSM stays in LOCKED.
REQ-019 SHALL latch a PLL loss flag on any cycle with pll_lock=0 and clear it at each frame end after evaluation.
REQ-020 SHALL handle FALLBACK: a non-match goes to SEARCH; a frame with no loss increments lock_cnt, else lock_cnt=0; at lock_cnt == LOCK_FRAMES the FSM enters LOCKED.
REQ-021 SHALL set the effective profile to the req_mode profile in LOCKED (req_mode 3 is treated as 0), and to PASSTHRU in SEARCH, VERIFY and FALLBACK.
REQ-022 SHALL use these profiles (LINEMULT, H_ACTIVE, H_BACKPORCH, H_SYNCLEN, V_ACTIVE, V_BACKPORCH, V_SYNCLEN):
  - PASSTHRU: 0, 960, 20, 20, 224, 28, 3.
  - DOUBLE: 1, 768, 132, 62, 240, 16, 3.
  - FIVEX: 2, 1920, 148, 44, 240, 16, 3.
REQ-023 SHALL load the config outputs only at frame end, in the same cycle as the state transition; a req_mode change takes effect at the next frame end.
REQ-024 SHALL pulse cfg_update for exactly one cycle, registered and coincident with the new config values, only when any config field changes.
REQ-025 SHALL drive mode_valid=1 only in LOCKED.
REQ-026 SHALL resolve a simultaneous pll_lock=0 and frame end by including the loss in that frame's evaluation.

Reset
REQ-027 SHALL, on reset, load the PASSTHRU config, set state=SEARCH, mode_valid=0, cfg_update=0, h_total=0, v_total=0, and clear all counters, flags and refs.
REQ-028 SHALL, on reset asserted mid-frame, discard the partial measurement, emit no cfg_update, and re-arm the first-frame-end ignore.

Verification
REQ-029 SHALL verify: reset, then stable 512x262 frames with req_mode=1, pll_lock=1 -> LOCKED at the 4th frame end after reset, one cfg_update, DOUBLE values, mode_valid=1.
REQ-030 SHALL verify: locked, then one frame at v_total 263 -> SEARCH and PASSTHRU at that frame end, cfg_update=1, mode_valid=0; relock after 3 further frames.
REQ-031 SHALL verify: locked in DOUBLE, pll_lock low for 1 cycle mid-frame -> FALLBACK plus PASSTHRU at frame end; LOCKED plus DOUBLE after 8 clean frames.
REQ-032 SHALL verify: line lengths alternating 512/515 -> frame bad, the FSM never leaves SEARCH/VERIFY, and h_total is reported correctly.
REQ-033 SHALL verify: no HSYNC for 5000 cycles -> counter saturates at 4095, frame invalid; a simultaneous H/V edge counts its line in v_total.
REQ-034 SHALL verify: req_mode 1->2 while LOCKED mid-frame -> FIVEX applied at the next frame end only, with one cfg_update; req_mode=3 gives PASSTHRU values while mode_valid=1.
